// File: rtl/bcd_counter_ndigit.sv
// Parametrised N-digit BCD up/down counter with clear, load, wrap/saturate,
// terminal-count flag and one-cycle overflow pulse. Carry resolves in one edge.
module bcd_counter_ndigit #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] cnt,
  output logic                tc,
  output logic                ovf
);

  logic [4*DIGITS-1:0] r_cnt;
  logic                r_ovf;
  logic [4*DIGITS-1:0] w_cnt_next;
  logic                w_ovf_next;
  logic [DIGITS-1:0]   w_step9;   // digits below k are all 9
  logic [DIGITS-1:0]   w_step0;   // digits below k are all 0
  logic                w_all9;
  logic                w_all0;
  logic                w_boundary;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [3:0] inc_digit(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] dec_digit(input logic [3:0] d);
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  // Prefix chains kept in local variables so no vector feeds back on itself.
  always_comb begin
    logic run9;
    logic run0;
    run9 = 1'b1;
    run0 = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      w_step9[k] = run9;
      w_step0[k] = run0;
      run9 = run9 & (r_cnt[4*k +: 4] == 4'd9);
      run0 = run0 & (r_cnt[4*k +: 4] == 4'd0);
    end
    w_all9 = run9;
    w_all0 = run0;
  end

  assign w_boundary = up ? w_all9 : w_all0;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    w_cnt_next = r_cnt;
    w_ovf_next = 1'b0;
    if (clr) begin
      w_cnt_next = '0;
    end else if (load) begin
      for (int k = 0; k < DIGITS; k++)
        w_cnt_next[4*k +: 4] = clamp_digit(load_val[4*k +: 4]);
    end else if (en) begin
      w_ovf_next = w_boundary;
      if (!(w_boundary && SATURATE)) begin
        for (int k = 0; k < DIGITS; k++) begin
          if (up && w_step9[k])
            w_cnt_next[4*k +: 4] = inc_digit(r_cnt[4*k +: 4]);
          else if (!up && w_step0[k])
            w_cnt_next[4*k +: 4] = dec_digit(r_cnt[4*k +: 4]);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_ovf <= w_ovf_next;
    end
  end

  assign cnt = r_cnt;
  assign ovf = r_ovf;
  assign tc  = w_boundary;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Bench for bcd_counter_ndigit: 2-digit wrap, 2-digit saturate and 4-digit
// wrap instances driven together and compared against integer-valued models.
module tb_bcd_counter_ndigit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
  logic [7:0]  lv2 = '0;
  logic [15:0] lv4 = '0;
  logic [7:0]  cnt2, cnts;
  logic [15:0] cnt4;
  logic        tc2, tcs, tc4, ovf2, ovfs, ovf4;

  int total = 0;
  int bad   = 0;

  // Reference state: plain decimal values plus expected ovf.
  int m2 = 0, ms = 0, m4 = 0;
  bit o2 = 0, os = 0, o4 = 0;

  always #5 clk = ~clk;

  bcd_counter_ndigit #(.DIGITS(2), .SATURATE(1'b0)) u_wrap2 (
    .clk(clk), .rst(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv2), .cnt(cnt2), .tc(tc2), .ovf(ovf2));

  bcd_counter_ndigit #(.DIGITS(2), .SATURATE(1'b1)) u_sat2 (
    .clk(clk), .rst(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv2), .cnt(cnts), .tc(tcs), .ovf(ovfs));

  bcd_counter_ndigit #(.DIGITS(4), .SATURATE(1'b0)) u_wrap4 (
    .clk(clk), .rst(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv4), .cnt(cnt4), .tc(tc4), .ovf(ovf4));

  function automatic logic [7:0] bcd8(input int v);
    return {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] bcd16(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic bit tc_exp(input int v, input int mx);
    return up ? (v == mx) : (v == 0);
  endfunction

  task automatic model_step(inout int v, inout bit o, input int digits,
                            input bit sat, input logic [31:0] lvv);
    int mx;
    int dg;
    mx = 10 ** digits - 1;
    o  = 1'b0;
    if (clr) begin
      v = 0;
    end else if (load) begin
      v = 0;
      for (int k = digits - 1; k >= 0; k--) begin
        dg = int'(lvv[4*k +: 4]);
        if (dg > 9) dg = 9;
        v = v * 10 + dg;
      end
    end else if (en) begin
      if (up) begin
        if (v == mx) begin o = 1'b1; if (!sat) v = 0; end
        else v = v + 1;
      end else begin
        if (v == 0) begin o = 1'b1; if (!sat) v = mx; end
        else v = v - 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(m2, o2, 2, 1'b0, {24'd0, lv2});
    model_step(ms, os, 2, 1'b1, {24'd0, lv2});
    model_step(m4, o4, 4, 1'b0, {16'd0, lv4});
    #1;
  endtask

  task automatic set_in(input logic e, input logic u, input logic c, input logic l);
    en = e; up = u; clr = c; load = l;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(0, 1, 0, 0);
    #1;
    total++;
    if ({cnt2, ovf2, tc2, cnt4, ovf4, tc4} !== {8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_up: got %h/%b/%b %h/%b/%b want 00/0/0 0000/0/0", cnt2, ovf2, tc2, cnt4, ovf4, tc4);
    end
    up = 1'b0;
    #1;
    total++;
    if ({tc2, tcs, tc4} !== 3'b111) begin
      bad++;
      $display("FAIL reset_tc_down: got tc=%b%b%b want 111", tc2, tcs, tc4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m2 = 0; ms = 0; m4 = 0; o2 = 0; os = 0; o4 = 0;
  endtask

  task automatic test_count_up();
    set_in(1, 1, 0, 0);
    for (int i = 0; i < 100; i++) begin
      cycle();
      total++;
      if ({cnt2, ovf2, tc2} !== {bcd8(m2), o2, tc_exp(m2, 99)}) begin
        bad++;
        $display("FAIL count_up[%0d]: got %h/%b/%b want %h/%b/%b", i, cnt2, ovf2, tc2, bcd8(m2), o2, tc_exp(m2, 99));
      end
      total++;
      if ({cnts, ovfs, cnt4, ovf4} !== {bcd8(ms), os, bcd16(m4), o4}) begin
        bad++;
        $display("FAIL count_up_other[%0d]: got %h/%b %h/%b want %h/%b %h/%b", i, cnts, ovfs, cnt4, ovf4, bcd8(ms), os, bcd16(m4), o4);
      end
    end
    total++;
    if (cnt2 !== 8'h00) begin
      bad++;
      $display("FAIL count_up_final: got %h want 00", cnt2);
    end
  endtask

  task automatic test_down_boundary();
    lv2 = 8'h00; lv4 = 16'h0000;
    set_in(0, 0, 0, 1);
    cycle();
    set_in(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if ({cnt2, ovf2} !== {bcd8(99 - i), (i == 0)}) begin
        bad++;
        $display("FAIL down_wrap[%0d]: got %h/%b want %h/%b", i, cnt2, ovf2, bcd8(99 - i), (i == 0));
      end
      total++;
      if ({cnts, ovfs, tcs} !== {8'h00, 1'b1, 1'b1}) begin
        bad++;
        $display("FAIL down_sat[%0d]: got %h/%b/%b want 00/1/1", i, cnts, ovfs, tcs);
      end
    end
  endtask

  task automatic test_clamp();
    lv2 = 8'h3C; lv4 = 16'hF93C;
    set_in(0, 1, 0, 1);
    cycle();
    total++;
    if ({cnt2, cnt4} !== {8'h39, 16'h9939}) begin
      bad++;
      $display("FAIL clamp_load: got %h %h want 39 9939", cnt2, cnt4);
    end
    set_in(1, 1, 0, 0);
    cycle();
    total++;
    if ({cnt2, cnt4, ovf2} !== {8'h40, 16'h9940, 1'b0}) begin
      bad++;
      $display("FAIL clamp_carry: got %h %h ovf=%b want 40 9940 0", cnt2, cnt4, ovf2);
    end
  endtask

  task automatic test_clr_priority();
    lv2 = 8'h99; lv4 = 16'h9999;
    set_in(0, 1, 0, 1);
    cycle();
    lv2 = 8'h55; lv4 = 16'h5555;
    set_in(1, 1, 1, 1);
    cycle();
    total++;
    if ({cnt2, ovf2, cnts, ovfs, cnt4, ovf4} !== {8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL clr_wins: got %h/%b %h/%b %h/%b want 00/0 00/0 0000/0", cnt2, ovf2, cnts, ovfs, cnt4, ovf4);
    end
    set_in(1, 1, 0, 1);
    cycle();
    total++;
    if ({cnt2, ovf2, cnt4} !== {8'h55, 1'b0, 16'h5555}) begin
      bad++;
      $display("FAIL load_wins: got %h/%b %h want 55/0 5555", cnt2, ovf2, cnt4);
    end
    lv2 = 8'h99; lv4 = 16'h9999;
    set_in(0, 1, 0, 1);
    cycle();
    set_in(1, 1, 0, 1);
    cycle();
    total++;
    if ({cnt2, ovf2, cnts, ovfs} !== {8'h99, 1'b0, 8'h99, 1'b0}) begin
      bad++;
      $display("FAIL load_at_boundary: got %h/%b %h/%b want 99/0 99/0", cnt2, ovf2, cnts, ovfs);
    end
  endtask

  task automatic test_carry4();
    lv4 = 16'h0999; lv2 = 8'h09;
    set_in(0, 1, 0, 1);
    cycle();
    set_in(1, 1, 0, 0);
    cycle();
    total++;
    if ({cnt4, ovf4, cnt2} !== {16'h1000, 1'b0, 8'h10}) begin
      bad++;
      $display("FAIL carry4_up: got %h/%b %h want 1000/0 10", cnt4, ovf4, cnt2);
    end
    set_in(1, 0, 0, 0);
    cycle();
    total++;
    if ({cnt4, ovf4, cnt2} !== {16'h0999, 1'b0, 8'h09}) begin
      bad++;
      $display("FAIL carry4_down: got %h/%b %h want 0999/0 09", cnt4, ovf4, cnt2);
    end
  endtask

  task automatic test_async_reset();
    lv2 = 8'h99; lv4 = 16'h9999;
    set_in(0, 1, 0, 1);
    cycle();
    set_in(1, 1, 0, 0);
    cycle();
    total++;
    if ({ovf2, ovfs, ovf4} !== 3'b111) begin
      bad++;
      $display("FAIL pre_reset_ovf: got %b%b%b want 111", ovf2, ovfs, ovf4);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({cnt2, ovf2, cnts, ovfs, cnt4, ovf4} !== {8'h00, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL async_reset_ovf: got %h/%b %h/%b %h/%b want zeros", cnt2, ovf2, cnts, ovfs, cnt4, ovf4);
    end
    rst_n = 1'b1;
    lv2 = 8'h47; lv4 = 16'h0047;
    set_in(0, 1, 0, 1);
    m2 = 0; ms = 0; m4 = 0; o2 = 0; os = 0; o4 = 0;
    cycle();
    set_in(1, 1, 0, 0);
    cycle();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({cnt2, ovf2, cnt4} !== {8'h00, 1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL async_reset_mid: got %h/%b %h want 00/0 0000", cnt2, ovf2, cnt4);
    end
    #1 rst_n = 1'b1;
    m2 = 0; ms = 0; m4 = 0; o2 = 0; os = 0; o4 = 0;
    cycle();
    total++;
    if ({cnt2, cnts, cnt4} !== {8'h01, 8'h01, 16'h0001}) begin
      bad++;
      $display("FAIL post_reset_first: got %h %h %h want 01 01 0001", cnt2, cnts, cnt4);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      up   = 1'($urandom_range(0, 1));
      clr  = ($urandom_range(0, 24) == 0);
      load = ($urandom_range(0, 9) == 0);
      lv2  = 8'($urandom);
      lv4  = 16'($urandom);
      #1;
      total++;
      if ({tc2, tcs, tc4} !== {tc_exp(m2, 99), tc_exp(ms, 99), tc_exp(m4, 9999)}) begin
        bad++;
        $display("FAIL rand_tc[%0d]: got %b%b%b want %b%b%b", i, tc2, tcs, tc4, tc_exp(m2, 99), tc_exp(ms, 99), tc_exp(m4, 9999));
      end
      cycle();
      total++;
      if ({cnt2, ovf2, cnts, ovfs, cnt4, ovf4} !== {bcd8(m2), o2, bcd8(ms), os, bcd16(m4), o4}) begin
        bad++;
        $display("FAIL rand_cnt[%0d]: got %h/%b %h/%b %h/%b want %h/%b %h/%b %h/%b", i,
                 cnt2, ovf2, cnts, ovfs, cnt4, ovf4, bcd8(m2), o2, bcd8(ms), os, bcd16(m4), o4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_down_boundary();
    test_clamp();
    test_clr_priority();
    test_carry4();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_counter_ndigit.md
# bcd_counter_ndigit

- Parametrised multi-digit BCD counter; the next generation of the single-digit 0-to-9 counter.
- Cascades `DIGITS` decimal digits, each 0–9.
- Adds up/down counting, synchronous clear and load, wrap or saturate mode, a terminal-count flag and an overflow pulse.
- Intended as the counting core for display, timer and event-counting blocks.

## Interface

Parameters:
- `DIGITS`, default 4: number of BCD digits, range 1–8.
- `SATURATE`, default 0: 0 = wrap at the boundary, 1 = hold at the boundary.

Ports:
- `clk` input 1: system clock, rising-edge active.
- `rst` input 1: reset, asynchronous, active-low.
- `en` input 1: count enable.
- `up` input 1: direction; 1 = increment, 0 = decrement.
- `clr` input 1: synchronous clear to zero.
- `load` input 1: synchronous load of `load_val`.
- `load_val` input 4*DIGITS: BCD load value; digit 0 is `[3:0]`, least significant.
- `cnt` output 4*DIGITS: registered BCD count; digit 0 is `[3:0]`.
- `tc` output 1: terminal count, combinational from `cnt` and `up`.
- `ovf` output 1: registered one-cycle overflow/underflow pulse.

## Operation

- Reset (`rst`=0, asynchronous):
  - `cnt`=0 and `ovf`=0 immediately.
  - The counter holds while `rst` is low.
- Per-edge priority: `clr` > `load` > `en` > hold.
  - `clr`=1: `cnt`=0, `ovf`=0.
  - `load`=1: each digit d takes `load_val` digit d. Any loaded digit above 9 is clamped to 9. `ovf`=0.
  - `en`=1, `up`=1: BCD increment. Digit 0 counts 9→0 and generates a carry. Digit k+1 steps only when digits 0..k are all 9.
  - `en`=1, `up`=0: BCD decrement. Digit 0 counts 0→9 and generates a borrow. Digit k+1 steps only when digits 0..k are all 0.
  - `en`=0: `cnt` holds. `ovf`=0.
- Boundary (all digits 9 and counting up, or all digits 0 and counting down, with `en`=1):
  - `SATURATE`=0: `cnt` wraps, all-9→all-0 or all-0→all-9. `ovf`=1 for that cycle.
  - `SATURATE`=1: `cnt` holds. `ovf`=1 for that cycle. `ovf` repeats every cycle while `en` stays high at the boundary.
- `tc`:
  - `tc`=1 when (`up`=1 and all digits are 9) or (`up`=0 and all digits are 0).
  - `tc` is independent of `en`.
  - After reset, `tc` = ~`up`.
- The count never holds a non-BCD digit. The digit range is always 0–9.
- Direction may change on any cycle. The new direction applies on the next counting edge with no lost or extra step.

## Timing

- Latency:
  - `cnt` and `ovf` change one `clk` edge after their inputs are sampled.
  - `tc` follows `cnt`/`up` combinationally in the same cycle.
- `ovf` asserts on the same edge that `cnt` wraps or saturates, and drops on the next edge unless the boundary condition recurs.
- `clr` or `load` coincident with a boundary count: the clear or load wins, and `ovf`=0.
- Carry is resolved within one cycle across all `DIGITS`. There is no ripple delay in cycles: 0999→1000 takes one edge.
- `rst` asserted mid-count: outputs clear asynchronously, regardless of `clk`. On release, the first count occurs on the first rising edge with `en`=1.

## Test plan

All scenarios use `DIGITS`=2 unless noted.

1. Reset, then `en`=1, `up`=1 for 100 cycles:
   - `cnt` steps 00,01…99,00.
   - `ovf` high only on the 99→00 edge.
   - `tc`=1 while `cnt`=99.
2. `load_val`=8'h00, load, then `en`=1, `up`=0 for 3 cycles:
   - `cnt` goes 99, 98, 97.
   - `ovf`=1 on the first edge (00→99).
   - Repeat with `SATURATE`=1: `cnt` stays 00 and `ovf` is high on every cycle.
3. `load_val`=8'h3C:
   - `cnt`=39 (low digit clamped).
   - Then `up`=1, one count: `cnt`=40. Carry is correct after the clamp.
4. `cnt`=99, `up`=1, `en`=1 with `clr`=1 and `load`=1 (`load_val`=8'h55) on the same edge:
   - `cnt`=00, `ovf`=0.
   - Next edge with `clr`=0, `load`=1: `cnt`=55.
5. `DIGITS`=4, load 0999, one up count:
   - `cnt`=1000 in one edge.
   - Then `up`=0, one count: `cnt`=0999.
6. Counting at 47, pulse `rst` low mid-cycle (between edges):
   - `cnt`=00 and `ovf`=0 immediately, without a clock edge.
   - After release, `en`=1: first edge gives 01.
